// File: rtl/mor1kx_spr_arbiter_if.sv
// mor1kx_spr_arbiter_if
//   Bundles the two requester handshakes (pipeline cpu_*, debug unit du_*),
//   the shared SPR bus and the two status pulses of mor1kx_spr_arbiter.
//   Signal suffixes are from the arbiter's point of view (_i = into it).
//   Modports:
//     slave  - the arbiter: takes requests and bus responses, drives acks,
//              read data, the bus strobe/command and the status pulses.
//     master - the environment (requesters plus SPR bus slave): the mirror.
interface mor1kx_spr_arbiter_if;
  logic        cpu_spr_req_i;
  logic        cpu_spr_we_i;
  logic [15:0] cpu_spr_addr_i;
  logic [31:0] cpu_spr_dat_i;
  logic        cpu_spr_ack_o;
  logic [31:0] cpu_spr_dat_o;

  logic        du_spr_req_i;
  logic        du_spr_we_i;
  logic [15:0] du_spr_addr_i;
  logic [31:0] du_spr_dat_i;
  logic        du_spr_ack_o;
  logic [31:0] du_spr_dat_o;

  logic        bus_spr_access_o;
  logic        bus_spr_we_o;
  logic [15:0] bus_spr_addr_o;
  logic [31:0] bus_spr_dat_o;
  logic        bus_spr_ack_i;
  logic [31:0] bus_spr_dat_i;

  logic        ro_err_o;
  logic        timeout_o;

  modport slave (
    input  cpu_spr_req_i, cpu_spr_we_i, cpu_spr_addr_i, cpu_spr_dat_i,
    output cpu_spr_ack_o, cpu_spr_dat_o,
    input  du_spr_req_i, du_spr_we_i, du_spr_addr_i, du_spr_dat_i,
    output du_spr_ack_o, du_spr_dat_o,
    output bus_spr_access_o, bus_spr_we_o, bus_spr_addr_o, bus_spr_dat_o,
    input  bus_spr_ack_i, bus_spr_dat_i,
    output ro_err_o, timeout_o
  );

  modport master (
    output cpu_spr_req_i, cpu_spr_we_i, cpu_spr_addr_i, cpu_spr_dat_i,
    input  cpu_spr_ack_o, cpu_spr_dat_o,
    output du_spr_req_i, du_spr_we_i, du_spr_addr_i, du_spr_dat_i,
    input  du_spr_ack_o, du_spr_dat_o,
    input  bus_spr_access_o, bus_spr_we_o, bus_spr_addr_o, bus_spr_dat_o,
    output bus_spr_ack_i, bus_spr_dat_i,
    input  ro_err_o, timeout_o
  );
endinterface

// File: rtl/mor1kx_spr_arbiter.sv
// mor1kx_spr_arbiter
//   Shares the single SPR access bus between the pipeline (cpu_*) and the
//   debug unit (du_*). Requests are serialised with round-robin arbitration,
//   forwarded to the bus, and completed with a one-cycle ack plus read data
//   to the granted requester. Writes to the read-only configuration SPRs
//   (group 0, index 0x0-0xF) never reach the bus; they are acked locally
//   with data 0 and flagged on ro_err_o.
// Ports:
//   clk  - core clock, rising edge
//   rst  - synchronous active-high reset
//   spr  - mor1kx_spr_arbiter_if.slave: requester handshakes, SPR bus,
//          ro_err_o / timeout_o pulses
// Parameters:
//   OPTION_SPR_TIMEOUT - ACCESS cycles without bus ack before abort (>=2)
// Build option:
//   SPR_ARB_TIMEOUT_EN - when defined, an ACCESS that sees no bus ack for
//   OPTION_SPR_TIMEOUT cycles is aborted: ack with data 0 and timeout_o.
//   When undefined, ACCESS waits indefinitely and timeout_o is tied 0.
module mor1kx_spr_arbiter #(
  parameter int OPTION_SPR_TIMEOUT = 16
) (
  input logic                    clk,
  input logic                    rst,
  mor1kx_spr_arbiter_if.slave    spr
);

  if (OPTION_SPR_TIMEOUT < 2) begin : g_bad_timeout
    $error("OPTION_SPR_TIMEOUT must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RO, RESP} state_t;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DU  = 1'b1;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        grant_q, grant_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] rdat_q, rdat_d;
  logic        ro_q, ro_d;
  logic        acked_q, acked_d;
`ifdef SPR_ARB_TIMEOUT_EN
  logic [7:0]  tcnt_q, tcnt_d;
  logic        to_q, to_d;
`endif

  logic cpu_req, du_req, sel;

  // The requester acked in the previous cycle is still dropping its req in
  // the IDLE that follows RESP; masking it avoids granting it twice.
  assign cpu_req = spr.cpu_spr_req_i && !(acked_q && grant_q == GNT_CPU);
  assign du_req  = spr.du_spr_req_i  && !(acked_q && grant_q == GNT_DU);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdat_d       = wdat_q;
    rdat_d       = rdat_q;
    ro_d         = ro_q;
    acked_d      = (state_q == RESP);
    sel          = GNT_CPU;
`ifdef SPR_ARB_TIMEOUT_EN
    tcnt_d       = tcnt_q;
    to_d         = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (cpu_req || du_req) begin
          // On a tie the requester not served last wins.
          sel          = (cpu_req && du_req) ? ~last_grant_q
                                             : (du_req ? GNT_DU : GNT_CPU);
          grant_d      = sel;
          last_grant_d = sel;
          we_d         = sel ? spr.du_spr_we_i   : spr.cpu_spr_we_i;
          addr_d       = sel ? spr.du_spr_addr_i : spr.cpu_spr_addr_i;
          wdat_d       = sel ? spr.du_spr_dat_i  : spr.cpu_spr_dat_i;
          rdat_d       = '0;
          ro_d         = 1'b0;
`ifdef SPR_ARB_TIMEOUT_EN
          tcnt_d       = '0;
          to_d         = 1'b0;
`endif
          // Group 0, index 0x0-0xF holds the read-only configuration SPRs.
          if (we_d && addr_d[15:4] == 12'h000) begin
            ro_d    = 1'b1;
            state_d = RO;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (spr.bus_spr_ack_i) begin
          rdat_d  = we_q ? 32'h0 : spr.bus_spr_dat_i;
          state_d = RESP;
        end
`ifdef SPR_ARB_TIMEOUT_EN
        // A bus ack in the expiry cycle takes the branch above instead.
        else if (tcnt_q == 8'(OPTION_SPR_TIMEOUT - 1)) begin
          rdat_d  = '0;
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
`endif
      end
      RO:      state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_DU;
      grant_q      <= GNT_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdat_q       <= '0;
      rdat_q       <= '0;
      ro_q         <= 1'b0;
      acked_q      <= 1'b0;
`ifdef SPR_ARB_TIMEOUT_EN
      tcnt_q       <= '0;
      to_q         <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdat_q       <= wdat_d;
      rdat_q       <= rdat_d;
      ro_q         <= ro_d;
      acked_q      <= acked_d;
`ifdef SPR_ARB_TIMEOUT_EN
      tcnt_q       <= tcnt_d;
      to_q         <= to_d;
`endif
    end
  end

  logic access, resp;
  assign access = (state_q == ACCESS);
  assign resp   = (state_q == RESP);

  // Bus command lines are held at 0 outside ACCESS.
  assign spr.bus_spr_access_o = access;
  assign spr.bus_spr_we_o     = access && we_q;
  assign spr.bus_spr_addr_o   = access ? addr_q : 16'h0;
  assign spr.bus_spr_dat_o    = access ? wdat_q : 32'h0;

  assign spr.cpu_spr_ack_o = resp && (grant_q == GNT_CPU);
  assign spr.du_spr_ack_o  = resp && (grant_q == GNT_DU);
  assign spr.cpu_spr_dat_o = spr.cpu_spr_ack_o ? rdat_q : 32'h0;
  assign spr.du_spr_dat_o  = spr.du_spr_ack_o  ? rdat_q : 32'h0;

  assign spr.ro_err_o = resp && ro_q;
`ifdef SPR_ARB_TIMEOUT_EN
  assign spr.timeout_o = resp && to_q;
`else
  assign spr.timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_mor1kx_spr_arbiter.sv
// Scoreboard bench for mor1kx_spr_arbiter: directed requests push expected
// bus commands and responses into queues; monitors pop and compare.
module tb_mor1kx_spr_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mor1kx_spr_arbiter_if bif();

  mor1kx_spr_arbiter #(.OPTION_SPR_TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .spr (bif.slave)
  );

  typedef struct {
    logic [31:0] dat;
    logic        ro;
    logic        to;
    int          lat;   // req-raise to ack in cycles, -1 = not checked
  } resp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] dat;
    int          len;   // ACCESS cycles, -1 = not checked
  } bus_t;

  resp_t cpu_q[$];
  resp_t du_q[$];
  bus_t  bus_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc[2];
  int bus_delay;
  int acc_cnt = 0;
  int acc_total = 0;
  logic model_ack = 1'b0;
  logic spur_ack  = 1'b0;
  logic [31:0] model_dat = 32'h0;

  assign bif.bus_spr_ack_i = model_ack | spur_ack;
  assign bif.bus_spr_dat_i = model_dat;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rd_of(input logic [15:0] a);
    return {a, 16'h0700 ^ a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus slave model: acks in ACCESS cycle number bus_delay (0-based).
  always @(negedge clk) begin
    if (bif.bus_spr_access_o) begin
      if (acc_cnt == bus_delay) begin
        model_ack = 1'b1;
        model_dat = rd_of(bif.bus_spr_addr_o);
      end else begin
        model_ack = 1'b0;
        model_dat = 32'hBAD0_BAD0;
      end
      acc_cnt++;
    end else begin
      model_ack = 1'b0;
      model_dat = 32'hBAD0_BAD0;
      acc_cnt   = 0;
    end
  end

  // Bus monitor: command on access rise, length on access fall.
  logic prev_acc = 1'b0;
  int   blen = 0;
  int   blen_exp = -1;
  always @(negedge clk) begin
    bus_t b;
    if (bif.bus_spr_access_o && !prev_acc) begin
      blen = 0;
      if (bus_q.size() == 0) begin
        chk("bus_unexpected", 32'd1, 32'd0);
        blen_exp = -1;
      end else begin
        b = bus_q.pop_front();
        chk("bus_we",   {31'h0, bif.bus_spr_we_o}, {31'h0, b.we});
        chk("bus_addr", {16'h0, bif.bus_spr_addr_o}, {16'h0, b.addr});
        chk("bus_wdat", bif.bus_spr_dat_o, b.dat);
        blen_exp = b.len;
      end
    end
    if (bif.bus_spr_access_o) begin
      blen++;
      acc_total++;
    end
    if (!bif.bus_spr_access_o && prev_acc && blen_exp >= 0)
      chk("bus_len", blen, blen_exp);
    prev_acc = bif.bus_spr_access_o;
  end

  // Response monitor.
  always @(negedge clk) begin
    resp_t r;
    if (!rst) begin
      if (bif.cpu_spr_ack_o) begin
        chk("cpu_other_quiet", {31'h0, bif.du_spr_ack_o} | bif.du_spr_dat_o, 32'h0);
        if (cpu_q.size() == 0) chk("cpu_ack_unexpected", 32'd1, 32'd0);
        else begin
          r = cpu_q.pop_front();
          chk("cpu_dat", bif.cpu_spr_dat_o, r.dat);
          chk("cpu_ro_err", {31'h0, bif.ro_err_o}, {31'h0, r.ro});
          chk("cpu_timeout", {31'h0, bif.timeout_o}, {31'h0, r.to});
          if (r.lat >= 0) chk("cpu_latency", cyc - req_cyc[0], r.lat);
        end
      end else if (bif.du_spr_ack_o) begin
        chk("du_other_quiet", bif.cpu_spr_dat_o, 32'h0);
        if (du_q.size() == 0) chk("du_ack_unexpected", 32'd1, 32'd0);
        else begin
          r = du_q.pop_front();
          chk("du_dat", bif.du_spr_dat_o, r.dat);
          chk("du_ro_err", {31'h0, bif.ro_err_o}, {31'h0, r.ro});
          chk("du_timeout", {31'h0, bif.timeout_o}, {31'h0, r.to});
          if (r.lat >= 0) chk("du_latency", cyc - req_cyc[1], r.lat);
        end
      end else begin
        chk("idle_quiet", bif.cpu_spr_dat_o | bif.du_spr_dat_o |
            {30'h0, bif.ro_err_o, bif.timeout_o}, 32'h0);
      end
    end
  end

  // One requester transaction; req held until ack, dropped after the
  // following IDLE cycle.
  task automatic xfer(input int w, input logic we, input logic [15:0] a, input logic [31:0] d);
    int  n;
    bit  got;
    @(negedge clk);
    if (w == 0) begin
      bif.cpu_spr_req_i = 1'b1; bif.cpu_spr_we_i = we;
      bif.cpu_spr_addr_i = a;   bif.cpu_spr_dat_i = d;
    end else begin
      bif.du_spr_req_i = 1'b1;  bif.du_spr_we_i = we;
      bif.du_spr_addr_i = a;    bif.du_spr_dat_i = d;
    end
    req_cyc[w] = cyc;
    n = 0;
    got = 1'b0;
    while (!got && n < 300) begin
      @(negedge clk);
      n++;
      got = (w == 0) ? bif.cpu_spr_ack_o : bif.du_spr_ack_o;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_wait requester=%0d actual=no_ack required=ack", w);
    end
    repeat (2) @(negedge clk);
    if (w == 0) begin
      bif.cpu_spr_req_i = 1'b0; bif.cpu_spr_we_i = 1'b0;
      bif.cpu_spr_addr_i = '0;  bif.cpu_spr_dat_i = '0;
    end else begin
      bif.du_spr_req_i = 1'b0;  bif.du_spr_we_i = 1'b0;
      bif.du_spr_addr_i = '0;   bif.du_spr_dat_i = '0;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_before;
    rst = 1'b1;
    bus_delay = -1;
    bif.cpu_spr_req_i = 1'b0; bif.cpu_spr_we_i = 1'b0;
    bif.cpu_spr_addr_i = '0;  bif.cpu_spr_dat_i = '0;
    bif.du_spr_req_i = 1'b0;  bif.du_spr_we_i = 1'b0;
    bif.du_spr_addr_i = '0;   bif.du_spr_dat_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_access", {31'h0, bif.bus_spr_access_o}, 32'h0);
    chk("rst_bus_cmd", {31'h0, bif.bus_spr_we_o} | {16'h0, bif.bus_spr_addr_o} | bif.bus_spr_dat_o, 32'h0);
    chk("rst_acks", {30'h0, bif.cpu_spr_ack_o, bif.du_spr_ack_o}, 32'h0);
    chk("rst_dats", bif.cpu_spr_dat_o | bif.du_spr_dat_o, 32'h0);
    chk("rst_flags", {30'h0, bif.ro_err_o, bif.timeout_o}, 32'h0);
    rst = 1'b0;

    // CPU read 0x0001, bus acks 2 cycles after access rises.
    bus_delay = 2;
    bus_q.push_back('{1'b0, 16'h0001, 32'h0, 3});
    cpu_q.push_back('{rd_of(16'h0001), 1'b0, 1'b0, 4});
    xfer(0, 1'b0, 16'h0001, 32'h0);

    // Simultaneous requests; CPU was served last, so DU wins each tie.
    for (int r = 0; r < 2; r++) begin
      bus_delay = 1;
      bus_q.push_back('{1'b0, 16'h0004, 32'h0, 2});
      bus_q.push_back('{1'b0, 16'h0805, 32'h0, 2});
      du_q.push_back('{rd_of(16'h0004), 1'b0, 1'b0, 3});
      cpu_q.push_back('{rd_of(16'h0805), 1'b0, 1'b0, -1});
      fork
        xfer(0, 1'b0, 16'h0805, 32'h0);
        xfer(1, 1'b0, 16'h0004, 32'h0);
      join
    end

    // DU write to read-only config SPR 0x0002: absorbed, no bus access.
    acc_before = acc_total;
    du_q.push_back('{32'h0, 1'b1, 1'b0, 2});
    xfer(1, 1'b1, 16'h0002, 32'hDEAD_BEEF);
    chk("ro_no_bus", acc_total - acc_before, 0);

    // Reading a config SPR does go to the bus.
    bus_delay = 0;
    bus_q.push_back('{1'b0, 16'h0002, 32'h0, 1});
    du_q.push_back('{rd_of(16'h0002), 1'b0, 1'b0, 2});
    xfer(1, 1'b0, 16'h0002, 32'h0);

    // CPU write 0x0011 is not read-only: normal bus write, write returns 0.
    bus_delay = 1;
    bus_q.push_back('{1'b1, 16'h0011, 32'h1234_5678, 2});
    cpu_q.push_back('{32'h0, 1'b0, 1'b0, 3});
    xfer(0, 1'b1, 16'h0011, 32'h1234_5678);

    // Bus ack while IDLE must be ignored.
    @(negedge clk); spur_ack = 1'b1;
    @(negedge clk); spur_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Bus ack in the 16th ACCESS cycle: normal completion.
    bus_delay = 15;
    bus_q.push_back('{1'b0, 16'h0020, 32'h0, 16});
    cpu_q.push_back('{rd_of(16'h0020), 1'b0, 1'b0, 17});
    xfer(0, 1'b0, 16'h0020, 32'h0);

`ifdef SPR_ARB_TIMEOUT_EN
    // Bus never acks: abort after 16 ACCESS cycles.
    bus_delay = -1;
    bus_q.push_back('{1'b0, 16'h0021, 32'h0, 16});
    cpu_q.push_back('{32'h0, 1'b0, 1'b1, 17});
    xfer(0, 1'b0, 16'h0021, 32'h0);
`endif

    // Reset during ACCESS: outputs cleared next cycle, request never acked.
    bus_delay = -1;
    bus_q.push_back('{1'b0, 16'h0003, 32'h0, -1});
    @(negedge clk);
    bif.cpu_spr_req_i = 1'b1; bif.cpu_spr_we_i = 1'b0;
    bif.cpu_spr_addr_i = 16'h0003; bif.cpu_spr_dat_i = 32'h0;
    repeat (3) @(negedge clk);
    chk("pre_rst_access", {31'h0, bif.bus_spr_access_o}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_access", {31'h0, bif.bus_spr_access_o}, 32'h0);
    chk("midrst_bus_cmd", {31'h0, bif.bus_spr_we_o} | {16'h0, bif.bus_spr_addr_o} | bif.bus_spr_dat_o, 32'h0);
    chk("midrst_acks", {30'h0, bif.cpu_spr_ack_o, bif.du_spr_ack_o}, 32'h0);
    bif.cpu_spr_req_i = 1'b0; bif.cpu_spr_addr_i = '0;
    rst = 1'b0;
    @(negedge clk);

    // After reset CPU wins the first tie.
    bus_delay = 0;
    bus_q.push_back('{1'b0, 16'h0806, 32'h0, 1});
    bus_q.push_back('{1'b0, 16'h0007, 32'h0, 1});
    cpu_q.push_back('{rd_of(16'h0806), 1'b0, 1'b0, 2});
    du_q.push_back('{rd_of(16'h0007), 1'b0, 1'b0, -1});
    fork
      xfer(0, 1'b0, 16'h0806, 32'h0);
      xfer(1, 1'b0, 16'h0007, 32'h0);
    join

    repeat (4) @(negedge clk);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("du_q_drained", du_q.size(), 0);
    chk("bus_q_drained", bus_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
